// File: rtl/tag_alloc_pipe.sv
// tag_alloc_pipe: allocates unique non-zero tags from a pool, carries them
// through NUM_COL column stages with per-column hold and bubble collapsing,
// and returns each tag to the pool when the last column retires it.
module tag_alloc_pipe #(
  parameter int unsigned NUM_COL = 8,
  parameter int unsigned NUM_TAG = 8,
  parameter int unsigned TAG_W   = $clog2(NUM_TAG + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alloc_req_i,
  output logic                       alloc_gnt_o,
  output logic [TAG_W-1:0]           alloc_tag_o,
  input  logic [NUM_COL-1:0]         col_hold_i,
  output logic [NUM_COL-1:0]         tag_vld_o,
  output logic [NUM_COL*TAG_W-1:0]   tag_out_o,
  output logic                       ret_vld_o,
  output logic [TAG_W-1:0]           ret_tag_o,
  input  logic                       ret_rdy_i,
  output logic [$clog2(NUM_TAG+1)-1:0] free_cnt_o,
  output logic                       busy_o
);

  localparam int unsigned CNT_W = $clog2(NUM_TAG + 1);

  // Stage registers and in-use bitmap (bit k tracks tag k+1)
  logic [NUM_COL-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]   tag_q [NUM_COL];
  logic [TAG_W-1:0]   tag_d [NUM_COL];
  logic [NUM_TAG-1:0] used_q, used_d;

  logic [NUM_COL-1:0] mv;
  logic               kill;
  logic               rdy0;
  logic               gnt;
  logic [TAG_W-1:0]   free_tag;
  logic [CNT_W-1:0]   used_cnt;
  logic [CNT_W-1:0]   free_cnt;
  logic               ret_vld;
  logic               ret_fire;
  logic [TAG_W-1:0]   ret_tag;

  // Reset and flush both discard everything and suppress grant/retirement
  assign kill = rst_i | flush_i;

  // Move chain, evaluated from the tail so each stage sees its successor's move
  always_comb begin
    mv = '0;
    mv[NUM_COL-1] = vld_q[NUM_COL-1] & ~col_hold_i[NUM_COL-1] & ret_rdy_i & ~kill;
    for (int i = int'(NUM_COL) - 2; i >= 0; i--) begin
      mv[i] = vld_q[i] & ~col_hold_i[i] & (~vld_q[i+1] | mv[i+1]);
    end
  end

  // Lowest free tag: scan high to low so the lowest index wins
  always_comb begin
    free_tag = '0;
    for (int k = int'(NUM_TAG) - 1; k >= 0; k--) begin
      if (!used_q[k]) begin
        free_tag = TAG_W'(k + 1);
      end
    end
  end

  // Occupancy from the bitmap
  always_comb begin
    used_cnt = '0;
    for (int k = 0; k < int'(NUM_TAG); k++) begin
      used_cnt = used_cnt + CNT_W'(used_q[k]);
    end
    free_cnt = CNT_W'(NUM_TAG) - used_cnt;
  end

  // Grant when stage 0 can accept and the pool is non-empty
  assign rdy0     = ~vld_q[0] | mv[0];
  assign gnt      = alloc_req_i & rdy0 & (free_cnt != '0) & ~kill;
  assign ret_vld  = vld_q[NUM_COL-1] & ~col_hold_i[NUM_COL-1] & ~kill;
  assign ret_tag  = ret_vld ? tag_q[NUM_COL-1] : '0;
  assign ret_fire = ret_vld & ret_rdy_i;

  // Next state: stage shifting, bubble collapse, and bitmap update
  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    used_d = used_q;

    if (gnt) begin
      vld_d[0] = 1'b1;
      tag_d[0] = free_tag;
    end else if (mv[0]) begin
      vld_d[0] = 1'b0;
      tag_d[0] = '0;
    end

    for (int i = 1; i < int'(NUM_COL); i++) begin
      if (mv[i-1]) begin
        vld_d[i] = 1'b1;
        tag_d[i] = tag_q[i-1];
      end else if (mv[i]) begin
        vld_d[i] = 1'b0;
        tag_d[i] = '0;
      end
    end

    // Retired tag cannot equal the granted one: it is still marked used
    for (int k = 0; k < int'(NUM_TAG); k++) begin
      if (ret_fire && (ret_tag == TAG_W'(k + 1))) begin
        used_d[k] = 1'b0;
      end
      if (gnt && (free_tag == TAG_W'(k + 1))) begin
        used_d[k] = 1'b1;
      end
    end

    if (kill) begin
      vld_d  = '0;
      used_d = '0;
      for (int i = 0; i < int'(NUM_COL); i++) begin
        tag_d[i] = '0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      used_q <= '0;
      for (int i = 0; i < int'(NUM_COL); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      used_q <= used_d;
      for (int i = 0; i < int'(NUM_COL); i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Flattened stage view; empty stages read as null tag
  always_comb begin
    tag_out_o = '0;
    for (int i = 0; i < int'(NUM_COL); i++) begin
      tag_out_o[i*TAG_W +: TAG_W] = vld_q[i] ? tag_q[i] : '0;
    end
  end

  assign alloc_gnt_o = gnt;
  assign alloc_tag_o = gnt ? free_tag : '0;
  assign tag_vld_o   = vld_q;
  assign ret_vld_o   = ret_vld;
  assign ret_tag_o   = ret_tag;
  assign free_cnt_o  = free_cnt;
  assign busy_o      = (|vld_q) | (|used_q);

endmodule

// File: tb/tb_tag_alloc_pipe.sv
// Bench for tag_alloc_pipe: scoreboard of expected grants/retirements with
// cycle stamps, directed state checks, and a per-cycle uniqueness invariant.
module tb_tag_alloc_pipe;

  localparam int NC  = 8;
  localparam int NT  = 8;
  localparam int TW  = 4;
  localparam int NT3 = 3;
  localparam int TW3 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic          rst, flush, req, rdy;
  logic [NC-1:0] hold;
  logic          gnt, rvld, busy;
  logic [TW-1:0] atag, rtag, fcnt;
  logic [NC-1:0] vld;
  logic [NC*TW-1:0] tout;

  tag_alloc_pipe #(.NUM_COL(NC), .NUM_TAG(NT)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .alloc_req_i(req),
    .alloc_gnt_o(gnt), .alloc_tag_o(atag), .col_hold_i(hold),
    .tag_vld_o(vld), .tag_out_o(tout), .ret_vld_o(rvld), .ret_tag_o(rtag),
    .ret_rdy_i(rdy), .free_cnt_o(fcnt), .busy_o(busy)
  );

  // Small-pool instance
  logic           req3;
  logic           flush3 = 1'b0;
  logic           rdy3 = 1'b1;
  logic [NC-1:0]  hold3 = '0;
  logic           gnt3, rvld3, busy3;
  logic [TW3-1:0] atag3, rtag3, fcnt3;
  logic [NC-1:0]  vld3;
  logic [NC*TW3-1:0] tout3;

  tag_alloc_pipe #(.NUM_COL(NC), .NUM_TAG(NT3)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush3), .alloc_req_i(req3),
    .alloc_gnt_o(gnt3), .alloc_tag_o(atag3), .col_hold_i(hold3),
    .tag_vld_o(vld3), .tag_out_o(tout3), .ret_vld_o(rvld3), .ret_tag_o(rtag3),
    .ret_rdy_i(rdy3), .free_cnt_o(fcnt3), .busy_o(busy3)
  );

  typedef struct { int tag; int cyc; } ev_t;
  ev_t gq[$];
  ev_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_en = 1'b0;
  bit inv_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void pg(input int tag, input int c);
    ev_t e;
    e.tag = tag; e.cyc = c;
    gq.push_back(e);
  endfunction

  function automatic void pr(input int tag, input int c);
    ev_t e;
    e.tag = tag; e.cyc = c;
    rq.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops plus structural invariant every cycle
  always @(negedge clk) begin
    if (sb_en) begin
      if (gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
        else begin
          ev_t e;
          e = gq.pop_front();
          chk("gnt_tag", atag, e.tag);
          chk("gnt_cyc", cyc, e.cyc);
        end
      end
      if (rvld && rdy) begin
        if (rq.size() == 0) chk("ret_unexpected", rvld, 0);
        else begin
          ev_t e;
          e = rq.pop_front();
          chk("ret_tag", rtag, e.tag);
          chk("ret_cyc", cyc, e.cyc);
        end
      end
    end
    if (inv_en) begin
      bit [15:0] seen;
      int cnt, bad, low;
      seen = '0; cnt = 0; bad = 0;
      for (int i = 0; i < NC; i++) begin
        int t;
        t = int'(tout[i*TW +: TW]);
        if (vld[i]) begin
          if (t == 0 || t > NT) bad++;
          else if (seen[t]) bad++;
          seen[t] = 1'b1;
          cnt++;
        end else if (t != 0) bad++;
      end
      chk("inv_unique", bad, 0);
      chk("inv_free_cnt", fcnt, NT - cnt);
      chk("inv_busy", busy, (cnt != 0));
      if (gnt) begin
        low = 0;
        for (int k = NT; k >= 1; k--) if (!seen[k]) low = k;
        chk("inv_lowest_tag", atag, low);
      end else chk("inv_tag_null", atag, 0);
      if (rst || flush) chk("inv_kill_gnt", gnt, 0);
      if (rvld) chk("inv_ret_tag", rtag, tout[(NC-1)*TW +: TW]);
      else chk("inv_ret_null", rtag, 0);
    end
  end

  initial begin
    int t0, v, s, u, f;
    int exp3_tag [12] = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    int exp3_cnt [12] = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    rst = 1'b1; flush = 1'b0; req = 1'b1; rdy = 1'b1; hold = '0; req3 = 1'b0;
    tick();
    inv_en = 1'b1;
    repeat (2) tick();
    #1;
    // Reset values (req high must still be refused)
    chk("rst_vld", vld, 0);
    chk("rst_tout", tout, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_rtag", rtag, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_atag", atag, 0);
    chk("rst_fcnt", fcnt, NT);
    chk("rst_busy", busy, 0);

    // Streaming allocation with immediate retirement
    tick();
    rst = 1'b0; sb_en = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 8; k++) pg(k, t0 + k - 1);
    pg(1, t0 + 9); pg(2, t0 + 10); pg(3, t0 + 11);
    for (int k = 1; k <= 8; k++) pr(k, t0 + 7 + k);
    pr(1, t0 + 17); pr(2, t0 + 18); pr(3, t0 + 19);
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) tick();
      req = (c < 12);
      #1;
      if (c == 1) chk("t1_fcnt_c1", fcnt, 7);
      if (c == 8) begin
        chk("t1_pool_empty_gnt", gnt, 0);
        chk("t1_pool_empty_fcnt", fcnt, 0);
      end
      if (c == 9)  chk("t1_fcnt_c9", fcnt, 1);
      if (c == 10) chk("t1_fcnt_same_cycle", fcnt, 1);
      if (c == 22) begin
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_fcnt", fcnt, NT);
        chk("t1_idle_vld", vld, 0);
      end
    end

    // Small pool: stalls when empty, resumes one cycle after retirement
    tick();
    v = cyc;
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) tick();
      req3 = (c < 12);
      #1;
      if (c < 12) begin
        chk("t2_atag", atag3, exp3_tag[c]);
        chk("t2_fcnt", fcnt3, exp3_cnt[c]);
      end
      if (c == 8) chk("t2_ret_tag1", rtag3, 1);
      if (c == 21) chk("t2_idle_busy", busy3, 0);
    end

    // Hold on column 4 with collapsing upstream bubbles
    tick();
    s = cyc;
    pg(1, s); pg(2, s + 2); pg(3, s + 3);
    pr(1, s + 13); pr(2, s + 14); pr(3, s + 15);
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) tick();
      req  = (c == 0 || c == 2 || c == 3);
      hold = (c >= 5 && c <= 9) ? 8'h10 : 8'h00;
      #1;
      if (c == 5) chk("t3_vld_c5", vld, 8'h16);
      if (c == 6) begin
        chk("t3_vld_collapsed", vld, 8'h1C);
        chk("t3_tout_collapsed", tout, 32'h0001_2300);
      end
      if (c == 9) begin
        chk("t3_vld_frozen", vld, 8'h1C);
        chk("t3_tout_frozen", tout, 32'h0001_2300);
        chk("t3_no_ret", rvld, 0);
      end
      if (c == 11) chk("t3_vld_released", vld, 8'h38);
      if (c == 17) chk("t3_idle_busy", busy, 0);
    end

    // Retirement backpressure under full traffic
    tick();
    u = cyc;
    for (int k = 1; k <= 8; k++) pg(k, u + k - 1);
    pg(1, u + 11);
    for (int k = 1; k <= 8; k++) pr(k, u + 9 + k);
    pr(1, u + 19);
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) tick();
      req = (c <= 11);
      rdy = (c > 9);
      #1;
      if (c == 8) begin
        chk("t4_rvld_c8", rvld, 1);
        chk("t4_rtag_c8", rtag, 1);
        chk("t4_gnt_blocked", gnt, 0);
      end
      if (c == 9) begin
        chk("t4_rtag_stable", rtag, 1);
        chk("t4_vld_full", vld, 8'hFF);
        chk("t4_fcnt_empty", fcnt, 0);
      end
      if (c == 10) chk("t4_no_regrant_same_cycle", gnt, 0);
      if (c == 21) chk("t4_idle_busy", busy, 0);
    end

    // Flush mid-stream
    tick();
    f = cyc;
    for (int k = 1; k <= 5; k++) pg(k, f + k - 1);
    pg(1, f + 6);
    pr(1, f + 14);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      req   = (c <= 6);
      flush = (c == 5);
      #1;
      if (c == 5) chk("t5_flush_gnt", gnt, 0);
      if (c == 6) begin
        chk("t5_after_vld", vld, 0);
        chk("t5_after_busy", busy, 0);
        chk("t5_after_fcnt", fcnt, NT);
      end
      if (c == 16) chk("t5_idle_busy", busy, 0);
    end
    chk("sb_grants_left", gq.size(), 0);
    chk("sb_rets_left", rq.size(), 0);

    // Random traffic with a mid-run reset; invariant checked every cycle
    tick();
    sb_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (i > 0) tick();
      if (i == 5001) begin
        rst = 1'b0; req = 1'b0; rdy = 1'b1; hold = '0;
        #1;
        chk("t6_rst_vld", vld, 0);
        chk("t6_rst_tout", tout, 0);
        chk("t6_rst_fcnt", fcnt, NT);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rvld", rvld, 0);
        chk("t6_rst_gnt", gnt, 0);
      end else begin
        rst = (i == 5000);
        req = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        for (int b = 0; b < NC; b++) hold[b] = ($urandom_range(0, 7) == 0);
      end
    end
    tick();
    req = 1'b0; hold = '0; rdy = 1'b1;
    repeat (NC + 2) tick();
    #1;
    chk("t6_drain_busy", busy, 0);
    chk("t6_drain_fcnt", fcnt, NT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_alloc_pipe.md
# tag_alloc_pipe

Parametrised tag allocator and tag-propagation pipeline for the PE column array. It owns a pool of unique non-zero tags, issues the lowest free tag on request, and carries each tag through NUM_COL column stages with per-column hold and bubble collapsing. It returns the tag to the pool when the last column retires it under a valid/ready handshake. It is the next generation of the column tag shifter: it guarantees tag uniqueness, supports backpressure and pool sizes that differ from the column count, and reports occupancy.

## Interface
- NUM_COL, 8, number of column stages (≥2)
- NUM_TAG, 8, tags in pool; legal tags 1..NUM_TAG, 0 = null (≥1)
- TAG_W, $clog2(NUM_TAG+1), derived tag width; not overridden
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of pipeline and pool, same effect as rst
- alloc_req  in  1  request a new tag into column 0
- alloc_gnt  out  1  request accepted this cycle (combinational)
- alloc_tag  out  TAG_W  tag granted; 0 when alloc_gnt=0
- col_hold  in  NUM_COL  per-column stall; held stage keeps its tag
- tag_vld  out  NUM_COL  stage i holds a tag
- tag_out  out  NUM_COL*TAG_W  flat; slice i = stage i tag, 0 when tag_vld[i]=0
- ret_vld  out  1  last stage presenting tag for retirement
- ret_tag  out  TAG_W  retiring tag; 0 when ret_vld=0
- ret_rdy  in  1  downstream accepts retirement
- free_cnt  out  $clog2(NUM_TAG+1)  tags currently free
- busy  out  1  any stage valid or any tag in use

## Operation
- State: stage registers vld[i], tag[i]; in-use bitmap used[1..NUM_TAG].
- Move chain (combinational, tail first): mv[N-1] = vld[N-1] & ~hold[N-1] & ret_rdy; mv[i] = vld[i] & ~hold[i] & (~vld[i+1] | mv[i+1]).
- Stage i+1 loads tag[i] when mv[i]. It clears when mv[i+1] and not mv[i]. Otherwise it keeps its contents. Bubbles collapse: a stage advances into an empty successor even if upstream is empty.
- Stage 0 ready: rdy0 = ~vld[0] | mv[0].
- Grant: alloc_gnt = alloc_req & rdy0 & (free_cnt≠0) & ~flush & ~rst. alloc_tag = lowest index k with used[k]=0.
- On grant: stage 0 loads alloc_tag with vld=1, and used[alloc_tag] is set at the same edge.
- Retirement: ret_vld = vld[N-1] & ~hold[N-1]; ret_tag = tag[N-1]. When ret_vld & ret_rdy, clear used[ret_tag] at the edge.
- A freed tag is not grantable in the same cycle it retires. It becomes grantable from the next cycle.
- free_cnt = NUM_TAG − popcount(used), combinational from the bitmap.
- busy = |vld | |used.
- Flush/reset: all vld=0, tags=0, used=0. No grant and no retirement are taken that cycle.
- Invariant: each non-zero tag appears at most once across the pipeline, and used[k]=1 iff tag k is in a stage. Assert this in the bench.
- When NUM_TAG < NUM_COL, allocation stalls when the pool is empty (alloc_gnt=0) while the pipeline keeps draining.

## Timing
- Reset values: tag_vld=0, tag_out=0, ret_vld=0, ret_tag=0, alloc_gnt=0, alloc_tag=0, free_cnt=NUM_TAG, busy=0.
- Grant at cycle t: tag_vld[0]=1 at t+1.
- Unstalled with ret_rdy=1: the tag reaches stage N-1 at t+NUM_COL, ret_vld is high that cycle, and the tag is free again at t+NUM_COL+1.
- Throughput: one grant and one retirement per cycle are sustained.
- Hold on stage i freezes stage i. Upstream stages fill in bubbles and then stall. Downstream stages continue to drain.
- ret_rdy=0: ret_vld stays high with a stable ret_tag until accepted, and the pipeline backs up.
- Grant and retirement can happen in the same cycle. free_cnt is unchanged net, and the retired tag is not the granted one.
- A flush asserted mid-stream discards in-flight tags. The cycle after flush, free_cnt=NUM_TAG and the next grant is tag 1.

## Test plan
- Reset, then alloc_req held high with ret_rdy=1 and no hold, NUM_COL=8, NUM_TAG=8: grants tags 1,2,3,…,8 on consecutive cycles; first ret_vld with tag 1 at cycle 8 after the first grant; tag 1 is re-granted the cycle after it retires.
- NUM_TAG=3, NUM_COL=8, continuous alloc_req: grants 1,2,3, then alloc_gnt=0 and free_cnt=0 until tag 1 retires; the next grant is 1, one cycle after retirement.
- Three tags in flight, col_hold[4]=1 for 5 cycles: the tag in stage 4 freezes, upstream tags collapse into stages 3,2 and stall, downstream drains; ordering is preserved after release.
- ret_rdy=0 for 10 cycles under full traffic: ret_tag stable, pipeline fills, alloc_gnt drops once stage 0 is blocked; no tag is lost or duplicated after ret_rdy=1.
- Flush with 5 tags in flight: the next cycle has tag_vld=0, busy=0, free_cnt=NUM_TAG; the next alloc_req grants tag 1.
- Randomised alloc_req/col_hold/ret_rdy for 10k cycles with the uniqueness assertion, plus rst asserted mid-run: returns to reset values in one cycle.
